// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI arbiter.
package spi_arb_pkg;

    localparam int NREQ         = 2;
    localparam int CS_SETUP_DEF = 4;
    localparam int CS_HOLD_DEF  = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        READY = 3'd2,
        START = 3'd3,
        BUSY  = 3'd4,
        DONE  = 3'd5,
        HOLD  = 3'd6
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Two-way round-robin pick: contention goes to the requester not granted last.
module spi_rr_pick
    import spi_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last,
    output logic [NREQ-1:0] win
);

    // last holds the index of the previous winner; reset leaves it at 1.
    always_comb begin
        win = '0;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = '0;
        endcase
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI byte engine between two requesters, each with its own chip select.
// Handshake: a byte moves on the clk edge where byte_valid[i] & byte_ready[i]; byte_ready is offered only to the granted requester while its req is held.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int CS_SETUP = CS_SETUP_DEF,
    parameter int CS_HOLD  = CS_HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      gnt,
    input  logic [NREQ-1:0]      byte_valid,
    input  logic [NREQ-1:0][7:0] byte_data,
    output logic [NREQ-1:0]      byte_ready,
    output logic [NREQ-1:0]      rx_valid,
    output logic [7:0]           rx_byte,
    output logic [NREQ-1:0]      cs_n,
    output logic                 spi_tx_start,
    output logic [7:0]           spi_tx_data,
    input  logic                 spi_tx_ready,
    input  logic [7:0]           spi_rx_data,
    output logic [2:0]           state_dbg
);

    localparam int CNT_W = $clog2(max_int(CS_SETUP, CS_HOLD) + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_run;
    logic              last;
    logic [NREQ-1:0]   win;
    logic              cur_req;
    logic              cur_valid;
    logic              take_grant;
    logic              take_byte;
    logic              take_rx;
    logic              drop_cs;

    spi_rr_pick u_pick (
        .req  (req),
        .last (last),
        .win  (win)
    );

    assign cur_req   = |(req & gnt);
    assign cur_valid = |(byte_valid & gnt);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_run      = 1'b0;
        take_grant   = 1'b0;
        take_byte    = 1'b0;
        take_rx      = 1'b0;
        drop_cs      = 1'b0;
        byte_ready   = '0;
        spi_tx_start = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    take_grant = 1'b1;
                    state_n    = SETUP;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) state_n = READY;
                else                   cnt_run = 1'b1;
            end
            READY: begin
                byte_ready = gnt & req;
                if (!cur_req) begin
                    state_n = HOLD;
                end else if (cur_valid) begin
                    take_byte = 1'b1;
                    state_n   = START;
                end
            end
            START: begin
                // Never kick the engine while it is still busy.
                spi_tx_start = spi_tx_ready;
                if (spi_tx_ready) state_n = BUSY;
            end
            BUSY: begin
                if (!spi_tx_ready) state_n = DONE;
            end
            DONE: begin
                if (spi_tx_ready) begin
                    take_rx = 1'b1;
                    state_n = READY;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    drop_cs = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_run = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            gnt         <= '0;
            cs_n        <= '1;
            last        <= 1'b1;
            spi_tx_data <= '0;
            rx_byte     <= '0;
            rx_valid    <= '0;
        end else begin
            cnt      <= cnt_run ? cnt + 1'b1 : '0;
            rx_valid <= '0;
            if (take_grant) begin
                gnt  <= win;
                cs_n <= ~win;
            end
            if (drop_cs) begin
                gnt  <= '0;
                cs_n <= '1;
                last <= gnt[1];
            end
            if (take_byte) spi_tx_data <= byte_data[gnt[1]];
            if (take_rx) begin
                rx_byte  <= spi_rx_data;
                rx_valid <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: behavioural SPI engine (100 clk/s, 10 baud, mode 0, MSB first) and a transaction-level reference.
module tb_spi_arbiter;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req = '0;
    logic [1:0]      gnt;
    logic [1:0]      byte_valid = '0;
    logic [1:0][7:0] byte_data = '0;
    logic [1:0]      byte_ready;
    logic [1:0]      rx_valid;
    logic [7:0]      rx_byte;
    logic [1:0]      cs_n;
    logic            spi_tx_start;
    logic [7:0]      spi_tx_data;
    logic            spi_tx_ready;
    logic [7:0]      spi_rx_data;
    logic [2:0]      state_dbg;

    int total = 0;
    int bad   = 0;

    spi_arbiter #(.CS_SETUP(4), .CS_HOLD(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .gnt          (gnt),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .cs_n         (cs_n),
        .spi_tx_start (spi_tx_start),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_ready (spi_tx_ready),
        .spi_rx_data  (spi_rx_data),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- SPI byte engine model ----------------
    // 10 clk per sclk period, 8 bits -> 80 clk byte time; miso comes from a shifted pattern.
    logic [7:0] miso_q[$];
    logic [7:0] mosi_log[$];
    int         eng_cnt;
    logic       eng_busy;
    logic [7:0] eng_tx, eng_miso, eng_rx, mosi_bits;
    logic       sclk, mosi;
    logic [2:0] bit_idx;

    assign bit_idx = 3'(7 - eng_cnt / 10);
    assign sclk    = eng_busy && ((eng_cnt % 10) >= 5);
    assign mosi    = eng_busy ? eng_tx[bit_idx] : 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_busy     <= 1'b0;
            spi_tx_ready <= 1'b1;
            spi_rx_data  <= '0;
            eng_cnt      <= 0;
            eng_tx       <= '0;
            eng_miso     <= '0;
            eng_rx       <= '0;
            mosi_bits    <= '0;
        end else if (!eng_busy) begin
            if (spi_tx_start) begin
                eng_busy     <= 1'b1;
                spi_tx_ready <= 1'b0;
                eng_cnt      <= 0;
                eng_tx       <= spi_tx_data;
                eng_miso     <= (miso_q.size() > 0) ? miso_q.pop_front() : 8'h00;
            end
        end else begin
            if ((eng_cnt % 10) == 5) begin
                eng_rx    <= {eng_rx[6:0], eng_miso[7]};
                eng_miso  <= {eng_miso[6:0], 1'b0};
                mosi_bits <= {mosi_bits[6:0], mosi};
            end
            if (eng_cnt == 79) begin
                eng_busy     <= 1'b0;
                spi_tx_ready <= 1'b1;
                spi_rx_data  <= eng_rx;
                mosi_log.push_back(mosi_bits);
            end
            eng_cnt <= eng_cnt + 1;
        end
    end

    // ---------------- monitor: invariants and cs timing ----------------
    int   cyc = 0;
    int   inv_err = 0;
    int   n_start = 0;
    int   glitch = 0;
    int   watch_w = -1;
    int   t_cs_lo = 0, t_sclk_fall = 0;
    int   min_setup = 1000, min_hold = 1000;
    bit   first_rise = 1'b0, had_byte = 1'b0;
    logic [1:0] prev_cs = 2'b11;
    logic       prev_sclk = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (cs_n == 2'b00) inv_err++;
            for (int i = 0; i < 2; i++) begin
                if (!cs_n[i] && !gnt[i])      inv_err++;
                if (byte_ready[i] && !gnt[i]) inv_err++;
                if (rx_valid[i] && !gnt[i])   inv_err++;
            end
            if (gnt == 2'b11) inv_err++;
            if (spi_tx_start && !spi_tx_ready) inv_err++;
            if (eng_busy && spi_tx_data != eng_tx) inv_err++;
            if (spi_tx_start) n_start++;
            if (watch_w >= 0 && cs_n[watch_w]) glitch++;
            if (prev_cs == 2'b11 && cs_n != 2'b11) begin
                t_cs_lo = cyc; first_rise = 1'b1; had_byte = 1'b0;
            end
            if (sclk && !prev_sclk && first_rise) begin
                if (cyc - t_cs_lo < min_setup) min_setup = cyc - t_cs_lo;
                first_rise = 1'b0;
            end
            if (!sclk && prev_sclk) begin
                t_sclk_fall = cyc; had_byte = 1'b1;
            end
            if (prev_cs != 2'b11 && cs_n == 2'b11 && had_byte) begin
                if (cyc - t_sclk_fall < min_hold) min_hold = cyc - t_sclk_fall;
            end
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
    end

    // ---------------- reference state and drivers ----------------
    int         rr_last = 1;
    logic [7:0] dir_data[$];
    logic [7:0] dir_miso[$];

    task automatic do_reset();
        req = '0; byte_valid = '0; byte_data = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rr_last = 1;
        miso_q.delete();
        mosi_log.delete();
        @(negedge clk);
    endtask

    // Runs transactions until each requester has finished its wanted count.
    task automatic session(input int want0, input int want1, input int nb_lo, input int nb_hi, input bit early);
        int want[2];
        int w, o, nb, to, starts0;
        logic [1:0] exp_g;
        logic [7:0] d, m;
        want[0] = want0; want[1] = want1;
        while (want[0] + want[1] > 0) begin
            req[0] = (want[0] > 0);
            req[1] = (want[1] > 0);
            if (want[0] > 0 && want[1] > 0) exp_g = (rr_last == 1) ? 2'b01 : 2'b10;
            else                            exp_g = (want[0] > 0) ? 2'b01 : 2'b10;
            to = 0;
            do begin @(negedge clk); to++; end while (gnt == 2'b00 && to < 20);
            check("gnt", gnt, exp_g);
            w = gnt[1] ? 1 : 0;
            o = 1 - w;
            rr_last = w;
            watch_w = w;
            glitch  = 0;
            starts0 = n_start;
            nb = (dir_data.size() > 0) ? dir_data.size() : $urandom_range(nb_hi, nb_lo);
            for (int b = 0; b < nb; b++) begin
                d = (dir_data.size() > 0) ? dir_data.pop_front() : 8'($urandom_range(255, 0));
                m = (dir_miso.size() > 0) ? dir_miso.pop_front() : 8'($urandom_range(255, 0));
                repeat ($urandom_range(2, 0)) @(negedge clk);
                byte_valid[o] = 1'($urandom_range(1, 0));
                byte_data[o]  = 8'($urandom_range(255, 0));
                byte_data[w]  = d;
                byte_valid[w] = 1'b1;
                miso_q.push_back(m);
                to = 0;
                while (!byte_ready[w] && to < 200) begin @(negedge clk); to++; end
                check("byte_ready_seen", byte_ready[w], 1'b1);
                @(negedge clk);
                byte_valid = '0;
                check("start_after_accept", spi_tx_start, 1'b1);
                check("tx_data", spi_tx_data, d);
                if (early && b == nb - 1) begin
                    @(negedge clk);
                    req[w] = 1'b0;
                end
                to = 0;
                while (!rx_valid[w] && to < 300) begin @(negedge clk); to++; end
                check("rx_valid", rx_valid[w], 1'b1);
                check("rx_byte", rx_byte, m);
                check("mosi_count", mosi_log.size(), 1);
                if (mosi_log.size() > 0) check("mosi_byte", mosi_log.pop_front(), d);
                if (b == nb - 1) begin
                    watch_w = -1;
                    req[w]  = 1'b0;
                end
                @(negedge clk);
                check("rx_pulse_width", rx_valid, 2'b00);
            end
            to = 0;
            while (gnt != 2'b00 && to < 30) begin @(negedge clk); to++; end
            check("gnt_released", gnt, 2'b00);
            check("cs_low_whole_txn", glitch, 0);
            check("start_count", n_start - starts0, nb);
            want[w]--;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int to, s0, w0, w1;
        req = 2'b11;
        byte_valid = 2'b11;
        repeat (2) @(negedge clk);
        check("rst_cs_n", cs_n, 2'b11);
        check("rst_gnt", gnt, 2'b00);
        check("rst_byte_ready", byte_ready, 2'b00);
        check("rst_rx_valid", rx_valid, 2'b00);
        check("rst_tx_start", spi_tx_start, 1'b0);
        check("rst_tx_data", spi_tx_data, 8'h00);
        check("rst_rx_byte", rx_byte, 8'h00);
        req = '0;
        rst = 1'b0;

        // byte_valid without req
        s0 = n_start;
        repeat (10) @(negedge clk);
        check("valid_no_req_gnt", gnt, 2'b00);
        check("valid_no_req_start", n_start - s0, 0);
        byte_valid = '0;

        // single byte C5 / DE
        dir_data.push_back(8'hC5);
        dir_miso.push_back(8'hDE);
        session(1, 0, 1, 1, 1'b0);

        // simultaneous after reset, then fairness with 2 bytes each
        do_reset();
        session(1, 1, 1, 1, 1'b0);
        session(2, 2, 2, 2, 1'b0);

        // early release on requester 1
        session(0, 1, 1, 2, 1'b1);

        // burst of three bytes
        dir_data = '{8'h01, 8'h02, 8'h03};
        dir_miso = '{8'hA1, 8'hB2, 8'hC3};
        session(1, 0, 3, 3, 1'b0);

        // randomized sessions
        repeat (6) begin
            w0 = $urandom_range(2, 0);
            w1 = $urandom_range(2, (w0 == 0) ? 1 : 0);
            session(w0, w1, 1, 3, 1'($urandom_range(1, 0)));
        end

        // reset during the 4th sclk pulse
        req = 2'b01;
        miso_q.push_back(8'h5A);
        to = 0;
        while (gnt != 2'b01 && to < 50) begin @(negedge clk); to++; end
        byte_data[0]  = 8'h96;
        byte_valid[0] = 1'b1;
        to = 0;
        while (!(eng_busy && eng_cnt == 36) && to < 300) begin
            @(negedge clk);
            if (spi_tx_start) byte_valid[0] = 1'b0;
            to++;
        end
        check("midrst_reached", (to < 300), 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_cs_n", cs_n, 2'b11);
        check("midrst_start", spi_tx_start, 1'b0);
        check("midrst_gnt", gnt, 2'b00);
        req = '0; byte_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rr_last = 1;
        miso_q.delete();
        mosi_log.delete();
        @(negedge clk);
        session(1, 1, 1, 1, 1'b0);

        repeat (5) @(negedge clk);
        check("invariants", inv_err, 0);
        check("cs_setup_ge4", (min_setup >= 4), 1'b1);
        check("cs_hold_ge4", (min_hold >= 4), 1'b1);
        check("miso_q_drained", miso_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
